// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with configurable bit period, data width and parity.
// Includes an RxD synchronizer, false-start rejection, stop/break checking and overrun flagging.
module uart_rx_param #(
  parameter int DIV    = 1302,
  parameter int DBITS  = 8,
  parameter int PARITY = 0,
  parameter int SYNC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RxD,
  input  logic             done,
  output logic             rdy,
  output logic [DBITS-1:0] data,
  output logic             pe,
  output logic             fe,
  output logic             ovr,
  output logic             busy
);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DBITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_e;

  state_e           state_q;
  logic [SYNC-1:0]  sync_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bcnt_q;
  logic [DBITS-1:0] shift_q;
  logic [DBITS-1:0] data_q;
  logic             perr_q;
  logic             rdy_q;
  logic             pe_q;
  logic             fe_q;
  logic             ovr_q;
  logic             busy_q;

  logic             rx;
  logic             bit_end;
  logic             commit;
  logic             par_err_d;
  logic [DBITS-1:0] shift_d;

  assign rx      = sync_q[SYNC-1];
  assign bit_end = (cnt_q == FULL_LAST);
  assign commit  = (state_q == S_STOP) && bit_end;
  assign shift_d = {rx, shift_q[DBITS-1:1]};
  // The parity bit joins the data XOR; odd parity expects the total to come out 1.
  assign par_err_d = (PARITY == 1) ? ~(^shift_q ^ rx) : (^shift_q ^ rx);

  // NOTE: every register here uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], RxD};

      case (state_q)
        S_IDLE: begin
          if (!rx) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bcnt_q  <= '0;
            state_q <= rx ? S_IDLE : S_DATA;
            busy_q  <= ~rx;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bcnt_q == BIT_LAST) begin
              bcnt_q  <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bcnt_q <= bcnt_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            perr_q  <= par_err_d;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            // A low stop bit after an all-zero word is a break; park until the line releases.
            if (!rx && (shift_q == '0)) begin
              state_q <= S_BRK;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BRK: begin
          if (rx) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase

      // A commit outranks a simultaneous done; ovr only latches when the old word was unread.
      if (commit) begin
        data_q <= shift_q;
        rdy_q  <= 1'b1;
        pe_q   <= perr_q;
        fe_q   <= ~rx;
        ovr_q  <= ovr_q | (rdy_q & ~done);
      end else if (done) begin
        rdy_q <= 1'b0;
        pe_q  <= 1'b0;
        fe_q  <= 1'b0;
        ovr_q <= 1'b0;
      end
    end
  end

  assign rdy  = rdy_q;
  assign data = data_q;
  assign pe   = pe_q;
  assign fe   = fe_q;
  assign ovr  = ovr_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a frame-level model predicts each commit edge and word, and
// a negedge process compares both receiver instances against it every cycle.
module tb_uart_rx_param;
  localparam int DIV  = 16;
  localparam int SYNC = 2;

  typedef struct {
    int         e;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic done0 = 1'b0, done1 = 1'b0;
  logic rdy0, pe0, fe0, ovr0, busy0;
  logic rdy1, pe1, fe1, ovr1, busy1;
  logic [7:0] data0, data1;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;
  int done_at0 = -10;
  int done_at1 = -10;
  bit chk_en = 1'b0;

  frame_t q0[$];
  frame_t q1[$];
  logic       m_rdy [2] = '{1'b0, 1'b0};
  logic       m_pe  [2] = '{1'b0, 1'b0};
  logic       m_fe  [2] = '{1'b0, 1'b0};
  logic       m_ovr [2] = '{1'b0, 1'b0};
  logic [7:0] m_data[2] = '{8'h00, 8'h00};

  logic rdy0_prev = 1'b0;
  int   rise0 = -1;

  always #5 clk = ~clk;

  uart_rx_param #(.DIV(DIV), .DBITS(8), .PARITY(0), .SYNC(SYNC)) dut0 (
    .clk(clk), .rst(rst), .RxD(rxd0), .done(done0),
    .rdy(rdy0), .data(data0), .pe(pe0), .fe(fe0), .ovr(ovr0), .busy(busy0)
  );

  uart_rx_param #(.DIV(DIV), .DBITS(8), .PARITY(2), .SYNC(SYNC)) dut1 (
    .clk(clk), .rst(rst), .RxD(rxd1), .done(done1),
    .rdy(rdy1), .data(data1), .pe(pe1), .fe(fe1), .ovr(ovr1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Output register behaviour at one clock edge, from the frame schedule and done.
  function automatic void model_step(int k, logic dn);
    frame_t f;
    bit     hit = 1'b0;
    if (!rst) begin
      m_rdy[k] = 1'b0; m_pe[k] = 1'b0; m_fe[k] = 1'b0; m_ovr[k] = 1'b0; m_data[k] = 8'h00;
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    if (k == 0 && q0.size() > 0 && q0[0].e == edge_n) begin f = q0.pop_front(); hit = 1'b1; end
    if (k == 1 && q1.size() > 0 && q1[0].e == edge_n) begin f = q1.pop_front(); hit = 1'b1; end
    if (hit) begin
      m_ovr[k]  = m_ovr[k] | (m_rdy[k] & ~dn);
      m_rdy[k]  = 1'b1;
      m_data[k] = f.d;
      m_pe[k]   = f.pe;
      m_fe[k]   = f.fe;
    end else if (dn) begin
      m_rdy[k] = 1'b0; m_pe[k] = 1'b0; m_fe[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endfunction

  task automatic tick();
    done0 = (done_at0 == edge_n + 1);
    done1 = (done_at1 == edge_n + 1);
    @(posedge clk);
    edge_n++;
    model_step(0, done0);
    model_step(1, done1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic hold(input int k, input logic v, input int n);
    if (k == 0) rxd0 = v; else rxd1 = v;
    repeat (n) tick();
  endtask

  task automatic pulse_done(input int k);
    if (k == 0) done_at0 = edge_n + 1; else done_at1 = edge_n + 1;
    tick();
  endtask

  // Drives start, 8 data bits LSB first, parity (instance 1 only) and stop; schedules the commit.
  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit, input logic stop);
    frame_t f;
    int nb;
    nb   = (k == 1) ? 11 : 10;
    f.e  = edge_n + 1 + SYNC + DIV / 2 + (nb - 1) * DIV;
    f.d  = d;
    f.pe = (k == 1) ? (^d ^ pbit) : 1'b0;
    f.fe = ~stop;
    if (k == 0) q0.push_back(f); else q1.push_back(f);
    hold(k, 1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(k, d[i], DIV);
    if (k == 1) hold(k, pbit, DIV);
    hold(k, stop, DIV);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0_out", 32'({rdy0, pe0, fe0, ovr0, data0}),
            32'({m_rdy[0], m_pe[0], m_fe[0], m_ovr[0], m_data[0]}));
      check("dut1_out", 32'({rdy1, pe1, fe1, ovr1, data1}),
            32'({m_rdy[1], m_pe[1], m_fe[1], m_ovr[1], m_data[1]}));
    end
    if (rdy0 === 1'b1 && rdy0_prev !== 1'b1) rise0 = edge_n;
    rdy0_prev = rdy0;
  end

  initial begin
    frame_t fb;
    int f1;
    int g;

    idle(3);
    rst = 1'b1;
    chk_en = 1'b1;
    check("reset_outputs", 32'({rdy0, pe0, fe0, ovr0, busy0, data0}), 32'h0);
    idle(5);

    // 8N1 0x55 and its latency from the first edge that sees RxD low.
    f1 = edge_n + 1;
    rise0 = -1;
    send_frame(0, 8'h55, 1'b0, 1'b1);
    check("t1_frame", 32'({rdy0, pe0, fe0, ovr0, data0}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h55}));
    check("t1_rdy_latency", 32'(rise0 - f1), 32'd154);
    pulse_done(0);
    idle(2);
    check("t1_after_done", 32'({rdy0, data0}), 32'({1'b0, 8'h55}));

    // Five-clock glitch is rejected at the start-bit midpoint.
    g = edge_n;
    hold(0, 1'b0, 5);
    check("t2_glitch_busy", 32'(busy0), 32'd1);
    hold(0, 1'b1, 10);
    check("t2_glitch_idle", 32'({busy0, rdy0}), 32'd0);
    idle(2 * DIV);
    send_frame(0, 8'hA3, 1'b0, 1'b1);
    check("t2_frame", 32'({rdy0, fe0, data0}), 32'({1'b1, 1'b0, 8'hA3}));
    pulse_done(0);

    // Even parity on instance 1.
    send_frame(1, 8'h07, 1'b0, 1'b1);
    check("t3_pe_set", 32'({rdy1, pe1, fe1, data1}), 32'({1'b1, 1'b1, 1'b0, 8'h07}));
    pulse_done(1);
    idle(4);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    check("t3_pe_clear", 32'({rdy1, pe1, fe1, data1}), 32'({1'b1, 1'b0, 1'b0, 8'h07}));

    // Framing error, then a held-low break line.
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    hold(0, 1'b1, 2 * DIV);
    check("t4_fe", 32'({rdy0, pe0, fe0, ovr0, data0}), 32'({1'b1, 1'b0, 1'b1, 1'b0, 8'h3C}));
    pulse_done(0);
    idle(4);
    fb.e = edge_n + 1 + SYNC + DIV / 2 + 9 * DIV;
    fb.d = 8'h00; fb.pe = 1'b0; fb.fe = 1'b1;
    q0.push_back(fb);
    hold(0, 1'b0, 200);
    check("t4_brk_frame", 32'({rdy0, fe0, ovr0, data0}), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
    pulse_done(0);
    hold(0, 1'b0, 40 * DIV - 201);
    check("t4_brk_hold", 32'({rdy0, busy0}), 32'({1'b0, 1'b1}));
    hold(0, 1'b1, SYNC + 2);
    check("t4_brk_exit", 32'({rdy0, busy0}), 32'd0);
    idle(2 * DIV);

    // Overrun, then done coincident with the second commit.
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    check("t5_overrun", 32'({rdy0, pe0, fe0, ovr0, data0}), 32'({1'b1, 1'b0, 1'b0, 1'b1, 8'h22}));
    pulse_done(0);
    idle(4);
    check("t5_done_clears", 32'({rdy0, ovr0, data0}), 32'({1'b0, 1'b0, 8'h22}));
    send_frame(0, 8'h11, 1'b0, 1'b1);
    done_at0 = edge_n + 1 + SYNC + DIV / 2 + 9 * DIV;
    send_frame(0, 8'h22, 1'b0, 1'b1);
    check("t5_done_commit", 32'({rdy0, pe0, fe0, ovr0, data0}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h22}));

    // Reset in the middle of data bit 4 abandons the frame.
    idle(DIV);
    hold(0, 1'b0, DIV);
    for (int i = 0; i < 4; i++) hold(0, 1'b0, DIV);
    hold(0, 1'b1, DIV / 2);
    check("t6_busy_before_rst", 32'(busy0), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_reset", 32'({rdy0, pe0, fe0, ovr0, busy0, data0}), 32'h0);
    idle(2 * DIV);
    send_frame(0, 8'hF0, 1'b0, 1'b1);
    check("t6_frame", 32'({rdy0, pe0, fe0, ovr0, data0}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'hF0}));
    idle(4);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
